spi_reg_initiator: RTL and testbench
====================================

# spi_reg_initiator

SPI target front end that converts serial frames from an external SPI controller into transactions on the team's register application interface (wr_rdn/addr/wdata/we, ack/err/rdata). It is the requester side of the register bus: it sits between the chip pins and the register bank and runs entirely in the system clock domain, oversampling the SPI pins.

## Interface
Parameters:
- ADDR_W, 8, register address width
- REG_W, 8, register data width
- TIMEOUT, 15, max clk cycles to wait for ack before aborting (≥1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ena  in  1  block enable; when 0, frames are ignored and no bus transaction starts
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- wr_rdn  out  1  1 = write, 0 = read
- addr  out  ADDR_W  register address
- wdata  out  REG_W  write data
- we  out  1  write enable
- rdata  in  REG_W  read data from register bank
- ack  in  1  transaction complete
- err  in  1  responder error, valid with ack
- busy  out  1  frame in progress
- status_err  out  1  sticky error for the last frame

## Operation
- Frame, MSB first: 1 command bit (1 = write), ADDR_W address bits, REG_W data bits; length FRAME_LEN = 1+ADDR_W+REG_W.
- sclk, cs_n, mosi pass through 2-flop synchronizers; rising/falling edges detected on synchronized sclk. mosi sampled on detected rising edge.
- FSM states: IDLE, HDR, BUS, DATA, DONE.
- IDLE: wait for synchronized cs_n falling (and ena=1); clear bit counter and status_err; go HDR.
- HDR: shift in 1+ADDR_W bits. After last header bit: read → BUS; write → DATA.
- DATA (write): shift in REG_W bits into wdata shift register; after last bit → BUS.
- BUS: drive addr, wr_rdn, wdata stable; we=1 for write. Hold until ack sampled 1, then deassert we next cycle. On ack: read → capture rdata into TX shift register and enter DATA; write → DONE. err with ack sets status_err. No ack within TIMEOUT cycles → status_err=1, drop we, go DONE (read: miso sends zeros).
- DATA (read): miso = TX MSB; shift TX on each detected falling edge after the first data-phase rising edge; mosi ignored.
- DONE: ignore further sclk edges; wait for cs_n high → IDLE.
- cs_n rising in any state → IDLE next cycle; a write with incomplete data never asserts we; an in-flight BUS transaction completes (we held to ack/timeout) before IDLE.
- Read late: if first data-phase rising edge arrives while still in BUS, status_err=1 and miso drives 0 for the frame.
- Bits beyond FRAME_LEN ignored.

## Timing
- Reset values: miso=0, wr_rdn=0, addr=0, wdata=0, we=0, busy=0, status_err=0; FSM IDLE.
- Synchronizer + edge detect latency: 3 clk from pin edge to internal event.
- Requirement on controller: sclk high and low phases each ≥ 6 clk cycles; read responder must ack within 2 clk to meet first data bit.
- BUS entered 1 clk after last header/data bit edge event; with ack tied high, we is high exactly 1 clk.
- miso updated 1 clk after detected falling edge; 0 whenever cs_n high or not in read DATA.
- busy=1 from cs_n-low detection to return to IDLE.
- Asynchronous rst mid-frame: all outputs to reset values immediately; next frame requires fresh cs_n falling edge.

## Structure
- Package spi_reg_pkg: state enum type, FRAME_LEN/header-length localparam functions, command-bit constants.
- One sub-module: spi_sync (2-flop synchronizer, reset value parameter: 1 for cs_n/sclk idle levels as applicable, 0 for mosi).

## Test plan
- Write frame cmd=1, addr=0x05, data=0xA5, ack tied 1 → we high 1 clk with addr=0x05, wdata=0xA5; status_err=0.
- Read frame addr=0x05, rdata returns 0xA5 → miso shifts 1,0,1,0,0,1,0,1 on data-phase rising edges.
- cs_n released after 12 of 17 bits of a write → we never asserts, FSM IDLE, busy=0.
- ack held 0 → we high for 15 clk, then dropped, status_err=1; next frame clears status_err.
- err=1 with ack on write to addr 0xFF → status_err=1, transaction completes.
- rst pulse mid-DATA of a read → miso=0, we=0, busy=0 immediately; following complete write frame succeeds.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register initiator.
// FSM encodings, command bit values and frame-length helpers.
package spi_reg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_BUS  = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    function automatic int hdr_len(input int addr_w);
        return 1 + addr_w;
    endfunction

    function automatic int frame_len(input int addr_w, input int reg_w);
        return 1 + addr_w + reg_w;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin.
// RST_VAL is the pin's idle level so reset does not fake an edge.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the pin into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_initiator.sv
// SPI mode-0 target that turns serial frames into register bus
// transactions; oversamples the SPI pins in the clk domain.
module spi_reg_initiator
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int REG_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_rdn,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    output logic              we,
    input  logic [REG_W-1:0]  rdata,
    input  logic              ack,
    input  logic              err,
    output logic              busy,
    output logic              status_err
);

    localparam int HDR_LEN   = hdr_len(ADDR_W);
    localparam int FRAME_LEN = frame_len(ADDR_W, REG_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int TMO_W     = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(REG_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic               sclk_s, cs_s, mosi_s;
    logic               sclk_d, cs_d;
    logic [1:0]         arm;
    logic               rise, fall, cs_fall;
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TMO_W-1:0]   tmo;
    logic [ADDR_W-1:0]  hdr;
    logic [HDR_LEN-1:0] hdr_nxt;
    logic [REG_W-1:0]   tx;
    logic               seen;
    logic               late;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sclk),
        .q   (sclk_s)
    );

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_s)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign cs_fall = (arm == 2'd3) & cs_d & ~cs_s;
    assign hdr_nxt = {hdr, mosi_s};
    assign busy    = (state != ST_IDLE);

    // Edge history; arm holds off cs detection until the
    // synchronizers have flushed their reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
            arm    <= 2'd0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            if (arm != 2'd3)
                arm <= arm + 2'd1;
        end
    end

    // Frame sequencing, bus handshake and miso shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tmo        <= '0;
            hdr        <= '0;
            tx         <= '0;
            seen       <= 1'b0;
            late       <= 1'b0;
            miso       <= 1'b0;
            wr_rdn     <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            we         <= 1'b0;
            status_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    miso <= 1'b0;
                    if (ena && cs_fall) begin
                        cnt        <= '0;
                        status_err <= 1'b0;
                        late       <= 1'b0;
                        state      <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end else if (rise) begin
                        hdr <= hdr_nxt[ADDR_W-1:0];
                        cnt <= cnt + 1'b1;
                        if (cnt == HDR_LAST) begin
                            cnt    <= '0;
                            addr   <= hdr_nxt[ADDR_W-1:0];
                            wr_rdn <= hdr_nxt[HDR_LEN-1];
                            if (hdr_nxt[HDR_LEN-1] == CMD_WRITE) begin
                                state <= ST_DATA;
                            end else begin
                                tmo   <= '0;
                                state <= ST_BUS;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_s) begin
                        miso  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (wr_rdn == CMD_WRITE) begin
                        if (rise) begin
                            wdata <= {wdata[REG_W-2:0], mosi_s};
                            cnt   <= cnt + 1'b1;
                            if (cnt == DAT_LAST) begin
                                we    <= 1'b1;
                                tmo   <= '0;
                                state <= ST_BUS;
                            end
                        end
                    end else begin
                        if (rise) begin
                            seen <= 1'b1;
                            cnt  <= cnt + 1'b1;
                            if (cnt == DAT_LAST) begin
                                miso  <= 1'b0;
                                state <= ST_DONE;
                            end
                        end else if (fall && seen) begin
                            miso <= tx[REG_W-1];
                            tx   <= {tx[REG_W-2:0], 1'b0};
                        end
                    end
                end
                ST_BUS: begin
                    if (rise && wr_rdn == CMD_READ) begin
                        late       <= 1'b1;
                        status_err <= 1'b1;
                    end
                    if (ack) begin
                        we <= 1'b0;
                        if (err)
                            status_err <= 1'b1;
                        if (wr_rdn == CMD_READ && !late && !rise) begin
                            miso  <= rdata[REG_W-1];
                            tx    <= {rdata[REG_W-2:0], 1'b0};
                            seen  <= 1'b0;
                            cnt   <= '0;
                            state <= ST_DATA;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (tmo == TMO_LAST) begin
                        we         <= 1'b0;
                        status_err <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_DONE: begin
                    miso <= 1'b0;
                    if (cs_s)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_initiator.sv
// Scoreboard bench for spi_reg_initiator: write strobes and read
// miso bits are checked against queued expectations by monitors.
module tb_spi_reg_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       wr_rdn;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata = 8'hA5;
    logic       ack = 1'b1;
    logic       err = 1'b0;
    logic       busy;
    logic       status_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         len;
    } wexp_t;

    wexp_t      wq[$];
    logic       mq[$];
    int         checks = 0;
    int         errors = 0;
    bit         rd_phase = 1'b0;
    logic       we_prev = 1'b0;
    int         we_len = 0;
    int         we_rises = 0;
    logic [7:0] cur_a;
    logic [7:0] cur_d;
    int         snap;

    spi_reg_initiator #(
        .ADDR_W  (8),
        .REG_W   (8),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .wr_rdn     (wr_rdn),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .rdata      (rdata),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .status_err (status_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: a we pulse is one write transaction.
    always @(negedge clk) begin
        if (we && !we_prev) begin
            we_rises++;
            cur_a  = addr;
            cur_d  = wdata;
            we_len = 1;
        end else if (we) begin
            we_len++;
        end
        if (!we && we_prev) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: got addr %0h expected none",
                         cur_a);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                chk("wr_addr", cur_a, e.a);
                chk("wr_data", cur_d, e.d);
                chk("we_len", we_len, e.len);
            end
        end
        we_prev = we;
    end

    // Controller-side sampling of miso on sclk rising edges.
    always @(posedge sclk) begin
        if (rd_phase) begin
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_miso: got %0b expected none", miso);
            end else begin
                chk("miso_bit", miso, mq.pop_front());
            end
        end
    end

    task automatic send_frame(input logic [16:0] f, input int nbits,
                              input bit rel);
        @(posedge clk);
        #2;
        cs_n = 1'b0;
        sclk = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("busy_start", busy, ena);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #2;
            mosi     = f[16-i];
            rd_phase = (f[16] == 1'b0) && (i >= 9);
            repeat (8) @(posedge clk);
            #2;
            sclk = 1'b1;
            repeat (8) @(posedge clk);
            #2;
            sclk     = 1'b0;
            rd_phase = 1'b0;
        end
        if (rel) begin
            repeat (8) @(posedge clk);
            #2;
            cs_n = 1'b1;
            mosi = 1'b0;
            repeat (24) @(posedge clk);
        end
    endtask

    task automatic push_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++)
            mq.push_back(v[7-i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", miso, 0);
        chk("rst_wr_rdn", wr_rdn, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_status", status_err, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Plain write, ack tied high.
        wq.push_back('{8'h05, 8'hA5, 1});
        send_frame({1'b1, 8'h05, 8'hA5}, 17, 1'b1);
        chk("wr1_status", status_err, 0);
        chk("wr1_busy_end", busy, 0);

        // Read of 0xA5.
        rdata = 8'hA5;
        push_bits(8'hA5, 8);
        send_frame({1'b0, 8'h05, 8'h00}, 17, 1'b1);
        chk("rd_status", status_err, 0);
        chk("rd_addr", addr, 8'h05);
        chk("rd_wr_rdn", wr_rdn, 0);
        chk("rd_miso_idle", miso, 0);

        // Write cut short after 12 bits.
        snap = we_rises;
        send_frame({1'b1, 8'h33, 8'hC3}, 12, 1'b1);
        chk("short_no_we", we_rises, snap);
        chk("short_busy", busy, 0);

        // No ack: strobe held for the full timeout.
        ack = 1'b0;
        wq.push_back('{8'h21, 8'h7E, 15});
        send_frame({1'b1, 8'h21, 8'h7E}, 17, 1'b1);
        chk("tmo_status", status_err, 1);
        chk("tmo_we_low", we, 0);
        ack = 1'b1;

        // Next frame clears the sticky error.
        wq.push_back('{8'h42, 8'h0F, 1});
        send_frame({1'b1, 8'h42, 8'h0F}, 17, 1'b1);
        chk("clr_status", status_err, 0);

        // Responder error on write.
        err = 1'b1;
        wq.push_back('{8'hFF, 8'h3C, 1});
        send_frame({1'b1, 8'hFF, 8'h3C}, 17, 1'b1);
        chk("err_status", status_err, 1);
        err = 1'b0;

        // Disabled block ignores a whole frame.
        ena  = 1'b0;
        snap = we_rises;
        send_frame({1'b1, 8'h10, 8'h55}, 17, 1'b1);
        chk("ena0_no_we", we_rises, snap);
        chk("ena0_status", status_err, 1);
        ena = 1'b1;

        // Reset during the read data phase.
        rdata = 8'hA5;
        push_bits(8'hA5, 3);
        send_frame({1'b0, 8'h05, 8'h00}, 12, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_miso", miso, 0);
        chk("arst_we", we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_status", status_err, 0);
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        wq.push_back('{8'h12, 8'h5A, 1});
        send_frame({1'b1, 8'h12, 8'h5A}, 17, 1'b1);
        chk("post_rst_status", status_err, 0);

        repeat (5) @(posedge clk);
        chk("wq_empty", wq.size(), 0);
        chk("mq_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
